// File: rtl/tff_mod_counter_pkg.sv
// ============================================================================
// Module  : tff_pkg
// Brief   : Shared types and elaboration helpers for the T-cell modulo counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tff_pkg;

    // Which update the counter applies on the next clock edge.
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_PRE  = 3'd1,
        OP_LD   = 3'd2,
        OP_UP   = 3'd3,
        OP_DN   = 3'd4
    } op_e;

    function automatic int unsigned clamp_val(input int unsigned v, input int unsigned m);
        return (v >= m) ? (m - 32'd1) : v;
    endfunction

    function automatic bit mod_ok(input int unsigned w, input int unsigned m);
        if (w < 32'd1 || m < 32'd2)
            return 1'b0;
        if (w >= 32'd32)
            return 1'b1;
        return (m <= (32'd1 << w));
    endfunction

endpackage : tff_pkg

`default_nettype wire

// File: rtl/tff_mod_counter_if.sv
// ============================================================================
// Module  : tff_mod_counter_if
// Brief   : Control/status bundle between the toggle-enable source and counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface tff_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             pre;
    logic             en;
    logic             up;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             wrap;

    modport master (
        output pre, en, up, ld, d,
        input  q, qn, tc, wrap
    );

    modport slave (
        input  pre, en, up, ld, d,
        output q, qn, tc, wrap
    );
endinterface : tff_mod_counter_if

`default_nettype wire

// File: rtl/tff_mod_counter_cell.sv
// ============================================================================
// Module  : tff_cell
// Brief   : One-bit T flip-flop with synchronous active-high clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_cell (
    input  wire logic clk,
    input  wire logic clr,
    input  wire logic t_i,
    output logic      q_o,
    output logic      qn_o
);
    logic q_q;
    logic qn_q;
    logic q_d;

    assign q_d = q_q ^ t_i;

    // qn is its own flop so the complement output is glitch-free.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_q  <= 1'b0;
            qn_q <= 1'b1;
        end else begin
            q_q  <= q_d;
            qn_q <= ~q_d;
        end
    end

    assign q_o  = q_q;
    assign qn_o = qn_q;
endmodule : tff_cell

`default_nettype wire

// File: rtl/tff_mod_counter.sv
// ============================================================================
// Module  : tff_mod_counter
// Brief   : Modulo-MOD up/down counter; every bit written via its T-cell toggle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  wire logic           clk,
    input  wire logic           clr,
    tff_mod_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   C_MOD = (WIDTH+1)'(MOD);

    if (!mod_ok(WIDTH, MOD)) begin : g_bad_mod
        $error("tff_mod_counter: MOD out of range for WIDTH");
    end

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [WIDTH-1:0] target_w;
    logic [WIDTH-1:0] t_w;
    logic [WIDTH-1:0] ld_val_w;
    logic             illegal_w;
    logic             tc_w;
    logic             wrap_q;
    op_e              op_w;

    assign illegal_w = ({1'b0, q_w} >= C_MOD);
    assign ld_val_w  = WIDTH'(clamp_val(32'(bus.d), 32'(MOD)));

    always_comb begin
        op_w = OP_HOLD;
        if (bus.pre)
            op_w = OP_PRE;
        else if (bus.ld)
            op_w = OP_LD;
        else if (bus.en)
            op_w = bus.up ? OP_UP : OP_DN;
    end

    // An out-of-range count re-enters the legal range at the natural wrap point.
    always_comb begin
        target_w = q_w;
        case (op_w)
            OP_PRE:  target_w = C_MAX;
            OP_LD:   target_w = ld_val_w;
            OP_UP:   target_w = (q_w == C_MAX || illegal_w) ? '0 : q_w + WIDTH'(1);
            OP_DN:   target_w = (q_w == '0 || illegal_w) ? C_MAX : q_w - WIDTH'(1);
            default: target_w = q_w;
        endcase
    end

    assign t_w = q_w ^ target_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .clr  (clr),
            .t_i  (t_w[i]),
            .q_o  (q_w[i]),
            .qn_o (qn_w[i])
        );
    end

    assign tc_w = bus.en & (bus.up ? (q_w == C_MAX) : (q_w == '0));

    always_ff @(posedge clk) begin
        if (clr)
            wrap_q <= 1'b0;
        else
            wrap_q <= ((op_w == OP_UP) || (op_w == OP_DN)) & tc_w;
    end

    assign bus.q    = q_w;
    assign bus.qn   = qn_w;
    assign bus.tc   = tc_w;
    assign bus.wrap = wrap_q;
endmodule : tff_mod_counter

`default_nettype wire

// File: tb/tb_tff_mod_counter.sv
// ============================================================================
// Module  : tb_tff_mod_counter
// Brief   : Directed + random bench against an arithmetic modulo-counter model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tff_mod_counter;
    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;
    int   m_cnt;
    int   m_wrap;
    bit   m_valid;

    tff_mod_counter_if #(.WIDTH(WIDTH)) bus ();

    tff_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model follows the counter rules with plain arithmetic.
    task automatic step(input bit c, input bit p, input bit e, input bit u,
                        input bit l, input int dv);
        int tc_m;
        @(negedge clk);
        clr     = c;
        bus.pre = p;
        bus.en  = e;
        bus.up  = u;
        bus.ld  = l;
        bus.d   = WIDTH'(dv);
        #1;
        tc_m = (e && (u ? (m_cnt == MOD - 1) : (m_cnt == 0))) ? 1 : 0;
        if (m_valid)
            check("tc", int'(bus.tc), tc_m);
        @(posedge clk);
        if (c) begin
            m_cnt = 0; m_wrap = 0;
        end else if (p) begin
            m_cnt = MOD - 1; m_wrap = 0;
        end else if (l) begin
            m_cnt = (dv >= MOD) ? MOD - 1 : dv; m_wrap = 0;
        end else if (e) begin
            m_wrap = tc_m;
            m_cnt  = u ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        end else begin
            m_wrap = 0;
        end
        if (c) m_valid = 1'b1;
        #1;
        if (m_valid) begin
            check("q",    int'(bus.q), m_cnt);
            check("qn",   int'(bus.qn), (~m_cnt) & ((1 << WIDTH) - 1));
            check("wrap", int'(bus.wrap), m_wrap);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        m_cnt = 0; m_wrap = 0; m_valid = 1'b0;
        clr = 1'b1; bus.pre = 1'b0; bus.en = 1'b0; bus.up = 1'b0;
        bus.ld = 1'b0; bus.d = '0;

        // reset held two cycles, then idle with en=0
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check("tc_idle", int'(bus.tc), 0);

        // count up through the wrap
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, 0);

        // back to 0, then count down through the wrap
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);

        // clamped load, then in-range load with en ignored
        step(0, 0, 1, 1, 1, 13);
        step(0, 0, 1, 0, 1, 5);

        // priority: pre over ld, clr over pre
        step(0, 1, 1, 1, 1, 2);
        step(1, 1, 1, 1, 1, 2);

        // direction flip each cycle from 7, then hold
        step(0, 0, 0, 0, 1, 7);
        for (int i = 0; i < 4; i++) step(0, 0, 1, (i % 2) == 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // boundary loads at the edges of the range
        step(0, 0, 0, 0, 1, MOD - 1);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 15);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_tff_mod_counter

`default_nettype wire
